// File: rtl/tx_ctrl_sm_param_if.sv
// Link-side signal bundle for the parametrised TX sequencer.
// master = sequencer side, slave = RX link / ROM / bench side.
interface tx_ctrl_sm_param_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 4,
  parameter int ADR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
);
  // Handshake: rx_ready is a level sampled only while the sequencer is idle;
  // once a word starts it always runs to completion. tx_vld qualifies every
  // serial slot on the line, with no backpressure inside a word.
  logic              rx_ready;
  logic              start;
  logic [DATA_W-1:0] word_in;
  logic [ADR_W-1:0]  adr;
  logic              read;
  logic              load;
  logic              shift;
  logic              tx_vld;
  logic              inc;
  logic              tx_par;
  logic              par_bit;
  logic              tx_finish;
  logic [2:0]        dbg_state;

  modport master (
    input  rx_ready, start, word_in,
    output adr, read, load, shift, tx_vld, inc, tx_par, par_bit, tx_finish,
    output dbg_state
  );

  modport slave (
    output rx_ready, start, word_in,
    input  adr, read, load, shift, tx_vld, inc, tx_par, par_bit, tx_finish,
    input  dbg_state
  );
endinterface

// File: rtl/tx_ctrl_sm_param.sv
// Parametrised TX sequencer: reads NUM_WORDS ROM words and strobes the shift register.
// Optional per-word parity slot enabled by defining TX_PARITY_EN.
module tx_ctrl_sm_param #(
  parameter int DATA_W    = 8,
  parameter int NUM_WORDS = 4,
  parameter int ADR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                clk,
  input  logic                clr,
  tx_ctrl_sm_param_if.master  bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 2);
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_SHIFT  = 3'd3,
    S_INC    = 3'd4,
    S_FINISH = 3'd5
`ifdef TX_PARITY_EN
    , S_PAR  = 3'd6
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic [ADR_W-1:0] adr_q;
  logic             last_word;

  logic read_q, load_q, shift_q, vld_q, inc_q, finish_q;
  logic read_nxt, load_nxt, shift_nxt, vld_nxt, inc_nxt, finish_nxt;

  assign last_word = (adr_q == LAST_ADR);

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:   state_nxt = bus.rx_ready ? S_READ : S_IDLE;
      S_READ:   state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (bit_cnt == BIT_LAST)
`ifdef TX_PARITY_EN
          state_nxt = S_PAR;
`else
          state_nxt = S_INC;
`endif
        else
          state_nxt = S_SHIFT;
      end
`ifdef TX_PARITY_EN
      S_PAR:    state_nxt = S_INC;
`endif
      S_INC:    state_nxt = last_word ? S_FINISH : S_IDLE;
      S_FINISH: state_nxt = bus.start ? S_IDLE : S_FINISH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so each one is a
  // pure function of the state register seen on the following cycle.
  always_comb begin
    read_nxt   = (state_nxt == S_READ);
    load_nxt   = (state_nxt == S_LOAD);
    shift_nxt  = (state_nxt == S_SHIFT);
    inc_nxt    = (state_nxt == S_INC);
    finish_nxt = (state_nxt == S_FINISH);
    vld_nxt    = (state_nxt == S_SHIFT) || (state_nxt == S_INC);
`ifdef TX_PARITY_EN
    vld_nxt    = vld_nxt || (state_nxt == S_PAR);
`endif
  end

`ifdef TX_PARITY_EN
  logic par_q;
  logic tx_par_q;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      adr_q    <= '0;
      bit_cnt  <= '0;
      read_q   <= 1'b0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      vld_q    <= 1'b0;
      inc_q    <= 1'b0;
      finish_q <= 1'b0;
`ifdef TX_PARITY_EN
      par_q    <= 1'b0;
      tx_par_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      if (state == S_LOAD)
        bit_cnt <= '0;
      else if (state == S_SHIFT)
        bit_cnt <= bit_cnt + CNT_W'(1);

      // Address never wraps mid-run: it only returns to 0 on the last word.
      if (state == S_INC)
        adr_q <= last_word ? '0 : adr_q + ADR_W'(1);
      else if ((state == S_FINISH) && bus.start)
        adr_q <= '0;

      read_q   <= read_nxt;
      load_q   <= load_nxt;
      shift_q  <= shift_nxt;
      vld_q    <= vld_nxt;
      inc_q    <= inc_nxt;
      finish_q <= finish_nxt;
`ifdef TX_PARITY_EN
      if (state == S_LOAD)
        par_q <= ^bus.word_in;
      tx_par_q <= (state_nxt == S_PAR);
`endif
    end
  end

  assign bus.adr       = adr_q;
  assign bus.read      = read_q;
  assign bus.load      = load_q;
  assign bus.shift     = shift_q;
  assign bus.tx_vld    = vld_q;
  assign bus.inc       = inc_q;
  assign bus.tx_finish = finish_q;
  assign bus.dbg_state = state;
`ifdef TX_PARITY_EN
  assign bus.tx_par    = tx_par_q;
  assign bus.par_bit   = par_q;
`else
  assign bus.tx_par    = 1'b0;
  assign bus.par_bit   = 1'b0;
`endif

endmodule

// File: tb/tb_tx_ctrl_sm_param.sv
// Bench for tx_ctrl_sm_param: directed reset/run/abort phases, then random traffic,
// checked each cycle against a per-word timeline model.
module tb_tx_ctrl_sm_param;

  localparam int DATA_W    = 8;
  localparam int NUM_WORDS = 4;
  localparam int ADR_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
`ifdef TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // {read, load, shift, tx_vld, inc, tx_par, tx_finish}
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_READ  = 7'b1000000;
  localparam logic [6:0] V_LOAD  = 7'b0100000;
  localparam logic [6:0] V_SHIFT = 7'b0011000;
  localparam logic [6:0] V_PAR   = 7'b0001010;
  localparam logic [6:0] V_INC   = 7'b0001100;
  localparam logic [6:0] V_FIN   = 7'b0000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  tx_ctrl_sm_param_if #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) bus ();

  tx_ctrl_sm_param #(.DATA_W(DATA_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- scoreboard / model ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [6:0]       exp_q[$];
  logic [6:0]       m_cur;
  logic [ADR_W-1:0] m_adr;
  logic             m_par;
  logic             m_fin;
  logic             m_idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  // A word accepted in idle is expanded into its whole slot timeline at once.
  task automatic model_step();
    if (clr) begin
      exp_q.delete();
      m_cur  = V_IDLE;
      m_adr  = '0;
      m_par  = 1'b0;
      m_fin  = 1'b0;
      m_idle = 1'b1;
    end else begin
      if (PAR_EN && (m_cur == V_LOAD))
        m_par = ^bus.word_in;
      if (m_cur == V_INC) begin
        if (m_adr == ADR_W'(NUM_WORDS - 1)) begin
          m_adr = '0;
          m_fin = 1'b1;
        end else begin
          m_adr = m_adr + ADR_W'(1);
        end
      end
      if (exp_q.size() != 0) begin
        m_cur  = exp_q.pop_front();
        m_idle = 1'b0;
      end else if (m_fin) begin
        if ((m_cur == V_FIN) && bus.start) begin
          m_fin  = 1'b0;
          m_cur  = V_IDLE;
          m_idle = 1'b1;
        end else begin
          m_cur  = V_FIN;
          m_idle = 1'b0;
        end
      end else if (m_idle && bus.rx_ready) begin
        exp_q.push_back(V_READ);
        exp_q.push_back(V_LOAD);
        for (int i = 0; i < DATA_W - 1; i++) exp_q.push_back(V_SHIFT);
        if (PAR_EN) exp_q.push_back(V_PAR);
        exp_q.push_back(V_INC);
        m_cur  = exp_q.pop_front();
        m_idle = 1'b0;
      end else begin
        m_cur  = V_IDLE;
        m_idle = 1'b1;
      end
    end
  endtask

  task automatic compare_outputs();
    check("strobes", 32'({bus.read, bus.load, bus.shift, bus.tx_vld,
                          bus.inc, bus.tx_par, bus.tx_finish}), 32'(m_cur));
    check("adr",     32'(bus.adr),     32'(m_adr));
    check("par_bit", 32'(bus.par_bit), 32'(m_par));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic c, input logic r, input logic s,
                      input logic [DATA_W-1:0] w);
    clr          = c;
    bus.rx_ready = r;
    bus.start    = s;
    bus.word_in  = w;
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] w_a7;
    w_a7 = DATA_W'(8'hA7);

    // reset then idle with rx_ready low
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, '0);

    // full run with rx_ready held, finish held, then restart
    for (int i = 0; i < 4 * (DATA_W + 4) + 6; i++) step(1'b0, 1'b1, 1'b0, w_a7);
    step(1'b0, 1'b0, 1'b1, w_a7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, w_a7);

    // abort in the 4th shift cycle, then restart
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, w_a7);
    step(1'b1, 1'b1, 1'b0, w_a7);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, DATA_W'($urandom));

    // rx_ready dropped mid-word, then reasserted after some idle cycles
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, DATA_W'($urandom));
    for (int i = 0; i < 20; i++) step(1'b0, (i >= 15), 1'b0, DATA_W'($urandom));

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 249) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 5) == 0),
           DATA_W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
